// File: rtl/cascade_counter.sv
// Two-stage cascaded counter (c0 low, c1 high) with programmable, shadow-buffered terminal limits.
// Latency: counts and strobes update one cycle after the enabling edge; reset clears them immediately.
// Backpressure: none; priority clr > ld > en. The macro CASCADE_COUNTER_SAT_EN selects saturating mode.
// Ports: clk/rst (async active-low), en/clr/ld + ld_lo/ld_hi, cfg_we + cfg_lo_max/cfg_hi_max,
//        c0/c1 counts, lo_tc/hi_tc one-cycle wrap strobes, cfg_pend, sat (saturating build only).
module cascade_counter #(
    parameter int unsigned LO_W       = 3,
    parameter int unsigned HI_W       = 16,
    parameter int unsigned LO_INIT    = 0,
    parameter int unsigned LO_RELOAD  = 1,
    parameter int unsigned HI_INIT    = 2,
    parameter int unsigned LO_MAX_DEF = 7,
    parameter int unsigned HI_MAX_DEF = 65535
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            clr,
    input  logic            ld,
    input  logic [LO_W-1:0] ld_lo,
    input  logic [HI_W-1:0] ld_hi,
    input  logic            cfg_we,
    input  logic [LO_W-1:0] cfg_lo_max,
    input  logic [HI_W-1:0] cfg_hi_max,
    output logic [LO_W-1:0] c0,
    output logic [HI_W-1:0] c1,
    output logic            lo_tc,
    output logic            hi_tc,
`ifdef CASCADE_COUNTER_SAT_EN
    output logic            sat,
`endif
    output logic            cfg_pend
);

    localparam logic [LO_W-1:0] LO_INIT_V    = LO_W'(LO_INIT);
    localparam logic [LO_W-1:0] LO_RELOAD_V  = LO_W'(LO_RELOAD);
    localparam logic [HI_W-1:0] HI_INIT_V    = HI_W'(HI_INIT);
    localparam logic [LO_W-1:0] LO_MAX_DEF_V = LO_W'(LO_MAX_DEF);
    localparam logic [HI_W-1:0] HI_MAX_DEF_V = HI_W'(HI_MAX_DEF);

    logic [LO_W-1:0] c0_q, c0_d;
    logic [HI_W-1:0] c1_q, c1_d;
    logic            lo_tc_q, lo_tc_d;
    logic            hi_tc_q, hi_tc_d;
    logic [LO_W-1:0] lo_max_q, lo_max_d;
    logic [HI_W-1:0] hi_max_q, hi_max_d;
    logic [LO_W-1:0] sh_lo_q, sh_lo_d;
    logic [HI_W-1:0] sh_hi_q, sh_hi_d;
    logic            pend_q, pend_d;
    logic            lo_hit, hi_hit;
    logic            apply_cfg;
    logic            cnt_en;
`ifdef CASCADE_COUNTER_SAT_EN
    logic            sat_q, sat_d;
`endif

    assign lo_hit = (c0_q == lo_max_q);
    assign hi_hit = (c1_q == hi_max_q);

`ifdef CASCADE_COUNTER_SAT_EN
    // Once saturated, counting is frozen until clr or ld releases it.
    assign cnt_en = en & ~sat_q;
`else
    assign cnt_en = en;
`endif

    // Count path. apply_cfg marks the two events that may promote the shadow limits.
    always_comb begin
        c0_d      = c0_q;
        c1_d      = c1_q;
        lo_tc_d   = 1'b0;
        hi_tc_d   = 1'b0;
        apply_cfg = 1'b0;
`ifdef CASCADE_COUNTER_SAT_EN
        sat_d     = sat_q;
`endif
        if (clr) begin
            c0_d      = LO_INIT_V;
            c1_d      = HI_INIT_V;
            apply_cfg = pend_q;
`ifdef CASCADE_COUNTER_SAT_EN
            sat_d     = 1'b0;
`endif
        end else if (ld) begin
            c0_d = ld_lo;
            c1_d = ld_hi;
`ifdef CASCADE_COUNTER_SAT_EN
            sat_d = 1'b0;
`endif
        end else if (cnt_en) begin
            if (!lo_hit) begin
                // A loaded value above the limit simply rolls over the top; no strobe.
                c0_d = c0_q + LO_W'(1);
            end else if (!hi_hit) begin
                c0_d    = LO_RELOAD_V;
                c1_d    = c1_q + HI_W'(1);
                lo_tc_d = 1'b1;
            end else begin
`ifdef CASCADE_COUNTER_SAT_EN
                // Hold at the limits; en is blocked afterwards so hi_tc fires only once.
                sat_d   = 1'b1;
                hi_tc_d = 1'b1;
`else
                c0_d      = LO_INIT_V;
                c1_d      = HI_INIT_V;
                lo_tc_d   = 1'b1;
                hi_tc_d   = 1'b1;
                apply_cfg = pend_q;
`endif
            end
        end
    end

    // Limit path. A write coinciding with an apply lands in the shadow after the
    // older pending value has been promoted, so it stays pending.
    always_comb begin
        lo_max_d = lo_max_q;
        hi_max_d = hi_max_q;
        sh_lo_d  = sh_lo_q;
        sh_hi_d  = sh_hi_q;
        pend_d   = pend_q;
        if (apply_cfg) begin
            lo_max_d = sh_lo_q;
            hi_max_d = sh_hi_q;
            pend_d   = 1'b0;
        end
        if (cfg_we) begin
            sh_lo_d = cfg_lo_max;
            sh_hi_d = cfg_hi_max;
            pend_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c0_q     <= LO_INIT_V;
            c1_q     <= HI_INIT_V;
            lo_tc_q  <= 1'b0;
            hi_tc_q  <= 1'b0;
            lo_max_q <= LO_MAX_DEF_V;
            hi_max_q <= HI_MAX_DEF_V;
            sh_lo_q  <= LO_MAX_DEF_V;
            sh_hi_q  <= HI_MAX_DEF_V;
            pend_q   <= 1'b0;
        end else begin
            c0_q     <= c0_d;
            c1_q     <= c1_d;
            lo_tc_q  <= lo_tc_d;
            hi_tc_q  <= hi_tc_d;
            lo_max_q <= lo_max_d;
            hi_max_q <= hi_max_d;
            sh_lo_q  <= sh_lo_d;
            sh_hi_q  <= sh_hi_d;
            pend_q   <= pend_d;
        end
    end

`ifdef CASCADE_COUNTER_SAT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat = sat_q;
`endif

    assign c0       = c0_q;
    assign c1       = c1_q;
    assign lo_tc    = lo_tc_q;
    assign hi_tc    = hi_tc_q;
    assign cfg_pend = pend_q;

endmodule

// File: tb/tb_cascade_counter.sv
module tb_cascade_counter;

    localparam int LO_W       = 3;
    localparam int HI_W       = 16;
    localparam int LO_INIT    = 0;
    localparam int LO_RELOAD  = 1;
    localparam int HI_INIT    = 2;
    localparam int LO_MAX_DEF = 7;
    localparam int HI_MAX_DEF = 65535;
    localparam int LO_MOD     = 1 << LO_W;
    localparam int HI_MOD     = 1 << HI_W;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            en = 1'b0, clr = 1'b0, ld = 1'b0, cfg_we = 1'b0;
    logic [LO_W-1:0] ld_lo = '0, cfg_lo_max = '0;
    logic [HI_W-1:0] ld_hi = '0, cfg_hi_max = '0;
    logic [LO_W-1:0] c0;
    logic [HI_W-1:0] c1;
    logic            lo_tc, hi_tc, cfg_pend;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state, plain integers.
    int m_c0, m_c1, m_lo_tc, m_hi_tc;
    int m_lo_max, m_hi_max, m_sh_lo, m_sh_hi, m_pend;

    cascade_counter dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .clr        (clr),
        .ld         (ld),
        .ld_lo      (ld_lo),
        .ld_hi      (ld_hi),
        .cfg_we     (cfg_we),
        .cfg_lo_max (cfg_lo_max),
        .cfg_hi_max (cfg_hi_max),
        .c0         (c0),
        .c1         (c1),
        .lo_tc      (lo_tc),
        .hi_tc      (hi_tc),
        .cfg_pend   (cfg_pend)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_c0 = LO_INIT;  m_c1 = HI_INIT;
        m_lo_tc = 0;     m_hi_tc = 0;
        m_lo_max = LO_MAX_DEF; m_hi_max = HI_MAX_DEF;
        m_sh_lo = LO_MAX_DEF;  m_sh_hi = HI_MAX_DEF;
        m_pend = 0;
    endtask

    // One clock of the counter's rules, evaluated on the inputs present at the edge.
    task automatic model_step();
        int full;
        full = 0;
        m_lo_tc = 0;
        m_hi_tc = 0;
        if (clr) begin
            m_c0 = LO_INIT; m_c1 = HI_INIT;
        end else if (ld) begin
            m_c0 = int'(ld_lo); m_c1 = int'(ld_hi);
        end else if (en) begin
            if (m_c0 != m_lo_max) begin
                m_c0 = (m_c0 + 1) % LO_MOD;
            end else if (m_c1 != m_hi_max) begin
                m_c0 = LO_RELOAD; m_c1 = (m_c1 + 1) % HI_MOD; m_lo_tc = 1;
            end else begin
                m_c0 = LO_INIT; m_c1 = HI_INIT; m_lo_tc = 1; m_hi_tc = 1; full = 1;
            end
        end
        if (m_pend != 0 && (clr || full != 0)) begin
            m_lo_max = m_sh_lo; m_hi_max = m_sh_hi; m_pend = 0;
        end
        if (cfg_we) begin
            m_sh_lo = int'(cfg_lo_max); m_sh_hi = int'(cfg_hi_max); m_pend = 1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".c0"},    c0,       m_c0);
        chk({tag, ".c1"},    c1,       m_c1);
        chk({tag, ".lo_tc"}, lo_tc,    m_lo_tc);
        chk({tag, ".hi_tc"}, hi_tc,    m_hi_tc);
        chk({tag, ".pend"},  cfg_pend, m_pend);
    endtask

    task automatic idle_inputs();
        en = 1'b0; clr = 1'b0; ld = 1'b0; cfg_we = 1'b0;
    endtask

    // Inputs are already set; clock them in, advance the model, sample 1 time unit later.
    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
        idle_inputs();
    endtask

    task automatic do_load(input int lo, input int hi);
        ld = 1'b1; ld_lo = LO_W'(lo); ld_hi = HI_W'(hi);
        step("load");
    endtask

    task automatic do_cfg(input int lo, input int hi);
        cfg_we = 1'b1; cfg_lo_max = LO_W'(lo); cfg_hi_max = HI_W'(hi);
        step("cfg");
    endtask

    task automatic run_en(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            en = 1'b1;
            step(tag);
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b1;

        // Default limits: 0..7, then 1..7 with c1 stepping, lo_tc on each wrap.
        run_en("count", 20);

        // Full wrap from the top of both stages.
        do_load(7, 65535);
        en = 1'b1;
        step("fullwrap");
        chk("fullwrap_hi_tc", hi_tc, 1);
        chk("fullwrap_c1", c1, 2);
        step("fullwrap_after");
        chk("fullwrap_hi_tc_drop", hi_tc, 0);

        // New limits written mid-count stay pending until the full wrap.
        run_en("pre_cfg", 3);
        do_cfg(3, 4);
        chk("cfg_pend_set", cfg_pend, 1);
        run_en("old_limits", 6);
        do_load(5, 65535);
        run_en("new_limits", 24);
        chk("cfg_applied", cfg_pend, 0);

        // clr beats ld and en, and promotes pending limits.
        do_cfg(5, 300);
        do_load(5, 9);
        clr = 1'b1; ld = 1'b1; en = 1'b1; ld_lo = 3'd6; ld_hi = 16'd40;
        step("clr_prio");
        chk("clr_prio_c0", c0, 0);
        chk("clr_prio_c1", c1, 2);

        // Loaded value above the limit rolls over the top silently.
        do_cfg(3, 4);
        clr = 1'b1;
        step("clr_apply");
        do_load(6, 2);
        run_en("over_limit", 8);

        // Write coinciding with clr stays pending.
        do_cfg(2, 6);
        clr = 1'b1; cfg_we = 1'b1; cfg_lo_max = 3'd5; cfg_hi_max = 16'd7;
        step("cfg_on_clr");
        chk("cfg_on_clr_pend", cfg_pend, 1);

        // Asynchronous reset mid-count.
        do_load(4, 100);
        do_cfg(1, 3);
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("async_rst_c0", c0, 0);
        chk("async_rst_c1", c1, 2);
        chk("async_rst_pend", cfg_pend, 0);
        #2 rst = 1'b1;
        do_load(7, 65535);
        en = 1'b1;
        step("rst_limits");

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            clr    = ($urandom_range(0, 31) == 0);
            ld     = ($urandom_range(0, 15) == 0);
            en     = ($urandom_range(0, 3) != 0);
            cfg_we = ($urandom_range(0, 31) == 0);
            ld_lo  = LO_W'($urandom_range(0, LO_MOD - 1));
            case ($urandom_range(0, 3))
                0:       ld_hi = HI_W'($urandom);
                1:       ld_hi = HI_W'(m_hi_max);
                2:       ld_hi = HI_W'((m_hi_max + HI_MOD - 1) % HI_MOD);
                default: ld_hi = HI_W'($urandom_range(0, 10));
            endcase
            cfg_lo_max = LO_W'($urandom_range(0, LO_MOD - 1));
            cfg_hi_max = ($urandom_range(0, 7) == 0) ? HI_W'(HI_MOD - 1)
                                                     : HI_W'($urandom_range(0, 12));
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
